// File: rtl/memory_game_core.sv
// rtl/memory_game_core.sv - single-engine LED memory game controller (classic/timed/reverse)
module memory_game_core #(
   parameter int NUM_SYMBOLS = 8,
   parameter int MAX_LEN     = 25,
   parameter int SHOW_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int TIME_LIMIT  = 60,
   localparam int SYM_W      = $clog2(NUM_SYMBOLS),
   localparam int CW         = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             mode,
   input  logic                   start,
   input  logic                   play_again,
   input  logic [SYM_W-1:0]       rnd,
   input  logic                   tick,
   input  logic                   btn_valid,
   input  logic [SYM_W-1:0]       btn_sym,
   output logic [NUM_SYMBOLS-1:0] led,
   output logic                   accepting,
   output logic                   game_over,
   output logic                   win,
   output logic [CW-1:0]          score,
   output logic [CW-1:0]          seq_len
);

   localparam int PW    = $clog2(SHOW_CYCLES + GAP_CYCLES + 1);
   localparam int TW    = $clog2(TIME_LIMIT + 1);
   localparam int DEPTH = 1 << CW;

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_OVER, S_WIN
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CW-1:0]    score_q, score_d;
   logic [CW-1:0]    seq_len_q, seq_len_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             mem_we;
   logic [SYM_W-1:0] mem_q [DEPTH];
   logic [SYM_W-1:0] expected;

   // Reverse mode reads the sequence from its tail.
   always_comb begin
      expected = mode_q[1] ? mem_q[CW'(seq_len_q - CW'(1) - idx_q)] : mem_q[idx_q];
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      score_d   = score_q;
      seq_len_d = seq_len_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      mem_we    = 1'b0;
      if (play_again && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_d    = mode;
                  score_d   = '0;
                  seq_len_d = '0;
                  state_d   = S_GEN;
               end
            end
            S_GEN: begin
               mem_we    = 1'b1;
               seq_len_d = seq_len_q + CW'(1);
               idx_d     = '0;
               cnt_d     = '0;
               state_d   = S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (cnt_q == PW'(SHOW_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = S_SHOW_OFF;
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
            end
            S_SHOW_OFF: begin
               if (cnt_q == PW'(GAP_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (idx_q + CW'(1) == seq_len_q) begin
                     idx_d   = '0;
                     timer_d = '0;
                     state_d = S_INPUT;
                  end else begin
                     idx_d   = idx_q + CW'(1);
                     state_d = S_SHOW_ON;
                  end
               end else begin
                  cnt_d = cnt_q + PW'(1);
               end
            end
            S_INPUT: begin
               // A final tick beats a press landing in the same cycle.
               if (mode_q[0] && tick && timer_q == TW'(TIME_LIMIT - 1)) begin
                  state_d = S_OVER;
               end else begin
                  if (mode_q[0] && tick) begin
                     timer_d = timer_q + TW'(1);
                  end
                  if (btn_valid) begin
                     if (btn_sym != expected) begin
                        state_d = S_OVER;
                     end else if (idx_q == seq_len_q - CW'(1)) begin
                        score_d = score_q + CW'(1);
                        state_d = (seq_len_q == CW'(MAX_LEN)) ? S_WIN : S_GEN;
                     end else begin
                        idx_d = idx_q + CW'(1);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         score_q   <= '0;
         seq_len_q <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         score_q   <= score_d;
         seq_len_q <= seq_len_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[seq_len_q] <= rnd;
      end
   end

   always_comb begin
      led = '0;
      if (state_q == S_SHOW_ON) begin
         led = NUM_SYMBOLS'(1) << mem_q[idx_q];
      end
   end

   assign accepting = (state_q == S_INPUT);
   assign game_over = (state_q == S_OVER);
   assign win       = (state_q == S_WIN);
   assign score     = score_q;
   assign seq_len   = seq_len_q;

endmodule

// File: tb/tb_memory_game_core.sv
// tb/tb_memory_game_core.sv - randomized scoreboard bench for memory_game_core
module tb_memory_game_core;

   localparam int NS = 8;
   localparam int SW = $clog2(NS);
   localparam int ML = 4;
   localparam int SC = 3;
   localparam int GC = 2;
   localparam int TL = 3;
   localparam int CW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    mode;
   logic          start;
   logic          play_again;
   logic [SW-1:0] rnd;
   logic          tick;
   logic          btn_valid;
   logic [SW-1:0] btn_sym;
   logic [NS-1:0] led;
   logic          accepting;
   logic          game_over;
   logic          win;
   logic [CW-1:0] score;
   logic [CW-1:0] seq_len;

   memory_game_core #(
      .NUM_SYMBOLS(NS), .MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC), .TIME_LIMIT(TL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .play_again(play_again),
      .rnd(rnd), .tick(tick), .btn_valid(btn_valid), .btn_sym(btn_sym), .led(led),
      .accepting(accepting), .game_over(game_over), .win(win), .score(score), .seq_len(seq_len)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit stuck   = 0;

   logic [SW-1:0] exp_led_sym[$];
   int            exp_led_len[$];
   int            exp_acc_len[$];
   int            exp_acc_score[$];
   logic [1:0]    exp_end[$];
   int            exp_end_score[$];

   logic [SW-1:0] mseq[$];
   int            mscore;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_round();
      foreach (mseq[i]) begin
         exp_led_sym.push_back(mseq[i]);
         exp_led_len.push_back(SC);
      end
      exp_acc_len.push_back(mseq.size());
      exp_acc_score.push_back(mscore);
   endtask

   // Noise on start/tick/btn while playback runs must be ignored.
   task automatic wait_accept();
      bit seen;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         cyc();
         if (accepting) begin
            seen = 1;
         end else begin
            start     = ($urandom_range(0, 3) == 0);
            tick      = ($urandom_range(0, 2) == 0);
            btn_valid = ($urandom_range(0, 3) == 0);
            btn_sym   = SW'($urandom);
         end
      end
      start     = 0;
      tick      = 0;
      btn_valid = 0;
      if (!seen) begin
         chk("accept_timeout", 0, 1);
         stuck = 1;
      end
   endtask

   task automatic play_game();
      logic [1:0]    m;
      logic [SW-1:0] e;
      logic [SW-1:0] sym;
      bit            done, press, t, correct, timed_out;
      int            timer, i, len, idle;
      m      = 2'($urandom_range(0, 3));
      mscore = 0;
      mseq.delete();
      mode   = m;
      start  = 1;
      rnd    = SW'($urandom);
      mseq.push_back(rnd);
      push_round();
      cyc();
      start = 0;
      mode  = 2'($urandom);
      wait_accept();
      if (stuck) return;
      done  = 0;
      timer = 0;
      i     = 0;
      while (!done) begin
         len  = mseq.size();
         e    = m[1] ? mseq[len - 1 - i] : mseq[i];
         idle = $urandom_range(0, 2);
         for (int k = 0; k <= idle && !done; k++) begin
            press     = (k == idle);
            t         = ($urandom_range(0, 4) == 0);
            tick      = t;
            correct   = ($urandom_range(0, 7) != 0);
            timed_out = 0;
            if (press) begin
               sym       = correct ? e : SW'((int'(e) + 1 + $urandom_range(0, NS - 2)) % NS);
               btn_valid = 1;
               btn_sym   = sym;
            end
            if (m[0] && t) begin
               if (timer == TL - 1) timed_out = 1;
               else timer++;
            end
            cyc();
            tick      = 0;
            btn_valid = 0;
            if (timed_out) begin
               exp_end.push_back(2'b10);
               exp_end_score.push_back(mscore);
               done = 1;
            end else if (press) begin
               if (!correct) begin
                  exp_end.push_back(2'b10);
                  exp_end_score.push_back(mscore);
                  done = 1;
               end else if (i == len - 1) begin
                  mscore++;
                  if (len == ML) begin
                     exp_end.push_back(2'b01);
                     exp_end_score.push_back(mscore);
                     done = 1;
                  end else begin
                     rnd = SW'($urandom);
                     mseq.push_back(rnd);
                     push_round();
                     wait_accept();
                     if (stuck) return;
                     timer = 0;
                     i     = 0;
                  end
               end else begin
                  i++;
               end
            end
         end
      end
      repeat ($urandom_range(1, 4)) cyc();
      play_again = 1;
      cyc();
      play_again = 0;
      chk("again_over", game_over, 0);
      chk("again_win", win, 0);
      chk("again_led", led, 0);
      chk("again_score", score, mscore);
   endtask

   // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
   logic [NS-1:0] led_prev = '0;
   logic          acc_prev = 0;
   logic          end_prev = 0;
   int            lit_cnt  = 0;
   int            lit_exp  = 0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (led != 0) begin
            if (led_prev == 0) begin
               if (exp_led_sym.size() == 0) begin
                  chk("led_unexpected", led, 0);
                  lit_exp = 0;
               end else begin
                  chk("led_sym", led, NS'(1) << exp_led_sym.pop_front());
                  lit_exp = exp_led_len.pop_front();
               end
               lit_cnt = 1;
            end else begin
               lit_cnt++;
            end
         end else if (led_prev != 0) begin
            chk("led_len", lit_cnt, lit_exp);
         end
         if (accepting && !acc_prev) begin
            if (exp_acc_len.size() == 0) begin
               chk("accept_unexpected", 1, 0);
            end else begin
               chk("accept_len", seq_len, exp_acc_len.pop_front());
               chk("accept_score", score, exp_acc_score.pop_front());
            end
         end
         if ((game_over || win) && !end_prev) begin
            if (exp_end.size() == 0) begin
               chk("end_unexpected", {game_over, win}, 0);
            end else begin
               chk("end_kind", {game_over, win}, exp_end.pop_front());
               chk("end_score", score, exp_end_score.pop_front());
            end
         end
      end
      led_prev = led;
      acc_prev = accepting;
      end_prev = game_over || win;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [SW-1:0] r;
      rst_n      = 0;
      mode       = 0;
      start      = 0;
      play_again = 0;
      rnd        = 0;
      tick       = 0;
      btn_valid  = 0;
      btn_sym    = 0;
      repeat (3) cyc();
      chk("rst_led", led, 0);
      chk("rst_accepting", accepting, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_win", win, 0);
      chk("rst_score", score, 0);
      chk("rst_seq_len", seq_len, 0);
      rst_n = 1;
      cyc();
      for (int g = 0; g < 60 && !stuck; g++) play_game();

      if (!stuck) begin
         mseq.delete();
         r     = SW'($urandom);
         mode  = 0;
         rnd   = r;
         start = 1;
         exp_led_sym.push_back(r);
         exp_led_len.push_back(1);
         cyc();
         start = 0;
         for (int c = 0; c < 10 && led == 0; c++) cyc();
         play_again = 1;
         cyc();
         play_again = 0;
         chk("abort_led", led, 0);
         chk("abort_accepting", accepting, 0);
         chk("abort_score", score, 0);
         repeat (5) cyc();
      end

      chk("left_led", exp_led_sym.size(), 0);
      chk("left_accept", exp_acc_len.size(), 0);
      chk("left_end", exp_end.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
